// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue (DEPTH-entry FIFO); IFID_BYPASS_EN adds an empty-queue same-cycle bypass.
// Latency: 1 cycle base / 0 with bypass; if_ready_o drops when full, decode stalls via id_ready_i, flush_i empties.
module if_id_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 4,
  parameter logic [DATA_W-1:0] NOP_INSTR = 'h00000013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     if_valid_i,
  input  logic [DATA_W-1:0]        if_instr_i,
  input  logic [ADDR_W-1:0]        if_addr_i,
  output logic                     if_ready_o,
  output logic                     id_valid_o,
  output logic [DATA_W-1:0]        id_instr_o,
  output logic [ADDR_W-1:0]        id_addr_o,
  input  logic                     id_ready_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              head_vld;
  logic              push;
  logic              pop;

  assign head_vld   = (count_q != '0);
  assign if_ready_o = (count_q != FULL);
  assign level_o    = count_q;

`ifdef IFID_BYPASS_EN
  logic bypass;
  assign bypass     = ~head_vld & if_valid_i & ~flush_i;
  assign id_valid_o = head_vld | bypass;
  assign id_instr_o = head_vld ? instr_mem_q[rd_ptr_q] : (bypass ? if_instr_i : NOP_INSTR);
  assign id_addr_o  = head_vld ? addr_mem_q[rd_ptr_q]  : (bypass ? if_addr_i  : '0);
  // A bypassed word taken by decode never touches storage.
  assign push = if_valid_i & if_ready_o & ~flush_i & ~(bypass & id_ready_i);
  assign pop  = head_vld & id_ready_i & ~flush_i;
`else
  assign id_valid_o = head_vld;
  assign id_instr_o = head_vld ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign id_addr_o  = head_vld ? addr_mem_q[rd_ptr_q]  : '0;
  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = head_vld & id_ready_i & ~flush_i;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= if_instr_i;
      addr_mem_q[wr_ptr_q]  <= if_addr_i;
    end
  end

endmodule
